// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Framed command parser between the UART receiver and transmitter. It decodes
// read/write frames (A5, CMD, ADDR, DATA for writes) against a small register
// file, mirrors register 0 onto the LED bank, and returns ACK/NAK/data bytes
// to the transmitter with a spacing that tolerates its busy-flag latency.
//
// Build option: define UART_CMD_CHKSUM_EN to require a trailing XOR checksum
// byte on every CMD/ADDR frame.
//
// Parameters:
//   DATA_WIDTH  byte width (framing constants assume 8)
//   ADDR_WIDTH  register file holds 2**ADDR_WIDTH bytes
//   TIMEOUT     clk_i cycles allowed between bytes of one frame
// Ports:
//   clk_i      sole clock (UART tx clock)
//   rst_i      synchronous active-low reset
//   rx_i       received byte, valid with rx_i_v
//   rx_i_v     one-cycle strobe per received byte
//   tx_busy_i  transmitter busy
//   tx_o       reply byte, held until the next strobe
//   tx_o_v     one-cycle strobe handing tx_o to the transmitter
//   led_o      register 0 contents
//   err_o      one-cycle pulse on frame error, timeout or overrun
module uart_cmd_parser #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] rx_i,
   input  logic                  rx_i_v,
   input  logic                  tx_busy_i,
   output logic [DATA_WIDTH-1:0] tx_o,
   output logic                  tx_o_v,
   output logic [DATA_WIDTH-1:0] led_o,
   output logic                  err_o
);

   localparam int TIMER_W = $clog2(TIMEOUT + 1);
   localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5;
   localparam logic [DATA_WIDTH-1:0] CMD_WRITE = 8'h57;
   localparam logic [DATA_WIDTH-1:0] CMD_READ  = 8'h52;
   localparam logic [DATA_WIDTH-1:0] ACK_BYTE  = 8'h06;
   localparam logic [DATA_WIDTH-1:0] NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_REPLY0, S_REPLY1
   } state_t;

`ifdef UART_CMD_CHKSUM_EN
   localparam state_t FIELDS_DONE = S_CHK;
`else
   localparam state_t FIELDS_DONE = S_EXEC;
`endif

   state_t                  state;
   logic                    is_write;
   logic                    nak;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH-1:0]   read_data;
   logic [DATA_WIDTH-1:0]   regs [0:(1<<ADDR_WIDTH)-1];
   logic [TIMER_W-1:0]      timer;
   logic                    tx_v_d1;
`ifdef UART_CMD_CHKSUM_EN
   logic [DATA_WIDTH-1:0]   chk;
`endif

   logic in_frame;
   logic expired;
   logic can_send;

   // Inter-byte timer only runs while a frame is partially received. A strobe
   // is allowed only if neither of the previous two cycles carried one, giving
   // the transmitter time to raise its busy flag.
   assign in_frame = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CHK);
   assign expired  = in_frame && (timer == TIMER_W'(TIMEOUT - 1));
   assign can_send = !tx_busy_i && !tx_o_v && !tx_v_d1;

   // Frame decoder, register file and reply sequencer in one registered FSM.
   // Every output is registered; tx_o_v and err_o default low so they pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= S_IDLE;
         is_write  <= 1'b0;
         nak       <= 1'b0;
         addr      <= '0;
         data      <= '0;
         read_data <= '0;
         timer     <= '0;
         tx_v_d1   <= 1'b0;
         tx_o      <= '0;
         tx_o_v    <= 1'b0;
         led_o     <= '0;
         err_o     <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
         chk       <= '0;
`endif
         for (int i = 0; i < (1 << ADDR_WIDTH); i++) regs[i] <= '0;
      end else begin
         tx_o_v  <= 1'b0;
         err_o   <= 1'b0;
         tx_v_d1 <= tx_o_v;
         // Expiry beats a byte arriving on the same edge; that byte is lost.
         if (expired) begin
            state <= S_IDLE;
            timer <= '0;
            err_o <= 1'b1;
         end else begin
            if (in_frame) timer <= rx_i_v ? '0 : timer + TIMER_W'(1);
            case (state)
               S_IDLE: begin
                  if (rx_i_v && rx_i == SYNC_BYTE) begin
                     state <= S_CMD;
                     timer <= '0;
                     nak   <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
                     chk   <= '0;
`endif
                  end
               end
               S_CMD: begin
                  if (rx_i_v) begin
`ifdef UART_CMD_CHKSUM_EN
                     chk <= chk ^ rx_i;
`endif
                     if (rx_i == CMD_WRITE || rx_i == CMD_READ) begin
                        is_write <= (rx_i == CMD_WRITE);
                        state    <= S_ADDR;
                     end else begin
                        // Unknown command: skip the rest and answer NAK.
                        nak   <= 1'b1;
                        state <= S_EXEC;
                     end
                  end
               end
               S_ADDR: begin
                  if (rx_i_v) begin
`ifdef UART_CMD_CHKSUM_EN
                     chk <= chk ^ rx_i;
`endif
                     addr <= rx_i[ADDR_WIDTH-1:0];
                     // Out-of-range address still consumes the full frame so
                     // the parser stays aligned, but it will be NAKed.
                     if (rx_i[DATA_WIDTH-1:ADDR_WIDTH] != '0) nak <= 1'b1;
                     state <= is_write ? S_DATA : FIELDS_DONE;
                  end
               end
               S_DATA: begin
                  if (rx_i_v) begin
`ifdef UART_CMD_CHKSUM_EN
                     chk <= chk ^ rx_i;
`endif
                     data  <= rx_i;
                     state <= FIELDS_DONE;
                  end
               end
`ifdef UART_CMD_CHKSUM_EN
               S_CHK: begin
                  if (rx_i_v) begin
                     if (rx_i != chk) nak <= 1'b1;
                     state <= S_EXEC;
                  end
               end
`endif
               S_EXEC: begin
                  if (rx_i_v) err_o <= 1'b1;
                  if (nak) begin
                     err_o <= 1'b1;
                  end else if (is_write) begin
                     regs[addr] <= data;
                     if (addr == '0) led_o <= data;
                  end else begin
                     read_data <= regs[addr];
                  end
                  state <= S_REPLY0;
               end
               S_REPLY0: begin
                  if (rx_i_v) err_o <= 1'b1;
                  if (can_send) begin
                     tx_o   <= nak ? NAK_BYTE : ACK_BYTE;
                     tx_o_v <= 1'b1;
                     state  <= (!nak && !is_write) ? S_REPLY1 : S_IDLE;
                  end
               end
               S_REPLY1: begin
                  if (rx_i_v) err_o <= 1'b1;
                  if (can_send) begin
                     tx_o   <= read_data;
                     tx_o_v <= 1'b1;
                     state  <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser in its default build (no checksum byte).
// Inputs change and outputs are read 1 ns after each falling edge; a monitor
// logs every reply strobe and counts err_o pulses.
module tb_uart_cmd_parser;

   localparam int TIMEOUT = 1000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx;
   logic       rx_v;
   logic       tx_busy;
   logic [7:0] tx;
   logic       tx_v;
   logic [7:0] led;
   logic       err;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         err_cnt = 0;
   int         err_base = 0;
   int         gap;
   logic [7:0] tx_q [$];
   int         sc_q [$];

   uart_cmd_parser #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .rx_i      (rx),
      .rx_i_v    (rx_v),
      .tx_busy_i (tx_busy),
      .tx_o      (tx),
      .tx_o_v    (tx_v),
      .led_o     (led),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   // Log reply bytes with their cycle number and count error pulses.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (tx_v === 1'b1) begin
         tx_q.push_back(tx);
         sc_q.push_back(cyc);
      end
      if (err === 1'b1) err_cnt = err_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // One received byte: strobe held for exactly one rising edge.
   task automatic applyStimulus(input logic [7:0] b);
      rx   = b;
      rx_v = 1'b1;
      step(1);
      rx_v = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         failures = failures + 1;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearLog();
      tx_q.delete();
      sc_q.delete();
      err_base = err_cnt;
   endtask

   task automatic waitReplies(input int n, input int budget);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         step(1);
         k++;
      end
   endtask

   function automatic logic [31:0] qAt(input int i);
      if (i < tx_q.size()) return {24'h0, tx_q[i]};
      return 32'hDEAD;
   endfunction

   initial begin
      rst_n   = 1'b0;
      rx      = 8'h00;
      rx_v    = 1'b0;
      tx_busy = 1'b0;
      step(3);
      checkOutput("reset_led", {24'h0, led}, 32'h00);
      checkOutput("reset_tx", {24'h0, tx}, 32'h00);
      checkOutput("reset_tx_v", {31'h0, tx_v}, 32'h0);
      checkOutput("reset_err", {31'h0, err}, 32'h0);
      rst_n = 1'b1;
      step(2);

      // Write 0x3C to register 0: LED follows one cycle after EXEC.
      $display("[TB] write reg0");
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h57);
      applyStimulus(8'h00); applyStimulus(8'h3C);
      checkOutput("wr_led_in_exec", {24'h0, led}, 32'h00);
      step(1);
      checkOutput("wr_led", {24'h0, led}, 32'h3C);
      waitReplies(1, 20);
      step(10);
      checkOutput("wr_count", tx_q.size(), 1);
      checkOutput("wr_ack", qAt(0), 32'h06);
      checkOutput("wr_err", err_cnt - err_base, 0);

      // Write 0x81 to register 5, then read it back.
      $display("[TB] write/read reg5");
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h57);
      applyStimulus(8'h05); applyStimulus(8'h81);
      waitReplies(1, 20);
      step(5);
      checkOutput("wr5_ack", qAt(0), 32'h06);
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h52); applyStimulus(8'h05);
      waitReplies(2, 40);
      step(5);
      checkOutput("rd_count", tx_q.size(), 2);
      checkOutput("rd_ack", qAt(0), 32'h06);
      checkOutput("rd_data", qAt(1), 32'h81);
      gap = (sc_q.size() >= 2) ? sc_q[1] - sc_q[0] : 0;
      checkOutput("rd_gap_ge3", {31'h0, gap >= 3}, 32'h1);
      checkOutput("rd_err", err_cnt - err_base, 0);

      // Unknown command byte.
      $display("[TB] bad command");
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h41);
      waitReplies(1, 20);
      step(5);
      checkOutput("badcmd_count", tx_q.size(), 1);
      checkOutput("badcmd_nak", qAt(0), 32'h15);
      checkOutput("badcmd_err", err_cnt - err_base, 1);

      // Address with upper bit set.
      $display("[TB] bad address");
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h52); applyStimulus(8'h09);
      waitReplies(1, 20);
      step(5);
      checkOutput("badaddr_count", tx_q.size(), 1);
      checkOutput("badaddr_nak", qAt(0), 32'h15);
      checkOutput("badaddr_err", err_cnt - err_base, 1);

      // Stall mid-frame until the inter-byte timer expires.
      $display("[TB] timeout");
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h57);
      step(TIMEOUT - 10);
      checkOutput("to_not_early", err_cnt - err_base, 0);
      step(20);
      checkOutput("to_err", err_cnt - err_base, 1);
      checkOutput("to_no_tx", tx_q.size(), 0);
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h52); applyStimulus(8'h00);
      waitReplies(2, 40);
      step(5);
      checkOutput("after_to_count", tx_q.size(), 2);
      checkOutput("after_to_ack", qAt(0), 32'h06);
      checkOutput("after_to_data", qAt(1), 32'h3C);

      // Transmitter held busy; a byte arriving during the reply is an overrun.
      $display("[TB] backpressure");
      clearLog();
      tx_busy = 1'b1;
      applyStimulus(8'hA5); applyStimulus(8'h52); applyStimulus(8'h05);
      step(50);
      applyStimulus(8'h77);
      step(149);
      checkOutput("bp_no_strobe", tx_q.size(), 0);
      checkOutput("bp_overrun_err", err_cnt - err_base, 1);
      tx_busy = 1'b0;
      waitReplies(2, 40);
      step(5);
      checkOutput("bp_ack", qAt(0), 32'h06);
      checkOutput("bp_data", qAt(1), 32'h81);

      // Reset in the middle of a write frame.
      $display("[TB] reset mid-frame");
      applyStimulus(8'hA5); applyStimulus(8'h57); applyStimulus(8'h01);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      checkOutput("rst_led", {24'h0, led}, 32'h00);
      checkOutput("rst_tx", {24'h0, tx}, 32'h00);
      checkOutput("rst_tx_v", {31'h0, tx_v}, 32'h0);
      checkOutput("rst_err", {31'h0, err}, 32'h0);
      clearLog();
      applyStimulus(8'h42);
      step(20);
      checkOutput("ign_err", err_cnt - err_base, 0);
      checkOutput("ign_tx", tx_q.size(), 0);
      clearLog();
      applyStimulus(8'hA5); applyStimulus(8'h52); applyStimulus(8'h05);
      waitReplies(2, 40);
      step(5);
      checkOutput("rst_rd_ack", qAt(0), 32'h06);
      checkOutput("rst_rd_cleared", qAt(1), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser sitting directly downstream of the UART receiver and upstream of the UART transmitter, in the transmitter's clock domain. It consumes received bytes, decodes framed read/write commands against a small internal register file, drives the LED bank from register 0, and emits acknowledge/data reply bytes to the transmitter. It replaces the plain echo path once the board needs host control.

## Interface
- DATA_WIDTH, 8, byte width; fixed at 8 for framing constants.
- ADDR_WIDTH, 3, register file depth is 2^ADDR_WIDTH bytes.
- TIMEOUT, 1000, clk_i cycles allowed between bytes of one frame.

- clk_i  in  1  sole clock, the UART tx clock.
- rst_i  in  1  synchronous, active-low reset.
- rx_i  in  8  received byte, valid when rx_i_v=1.
- rx_i_v  in  1  one-cycle strobe per received byte.
- tx_busy_i  in  1  transmitter busy; high while a byte is shifting out.
- tx_o  out  8  reply byte, valid when tx_o_v=1.
- tx_o_v  out  1  one-cycle strobe handing tx_o to the transmitter.
- led_o  out  8  register 0 contents.
- err_o  out  1  one-cycle pulse on any frame error, timeout or overrun.

## Operation
- Frame: SYNC 0xA5, CMD, ADDR, DATA (write only), CHK (only with checksum build).
- CMD 0x57 'W' = write, 0x52 'R' = read; any other value is an error.
- ADDR: low ADDR_WIDTH bits select a register; any nonzero upper bit is an error.
- States: IDLE, CMD, ADDR, DATA, CHK, EXEC, REPLY0, REPLY1.
- IDLE: non-0xA5 bytes ignored silently, no err_o; 0xA5 -> CMD.
- CMD: valid cmd -> ADDR; invalid -> EXEC flagged NAK.
- ADDR: write -> DATA; read -> CHK (checksum build) or EXEC.
- DATA -> CHK (checksum build) or EXEC.
- EXEC, one cycle: write commits regs[addr] <= data; read latches regs[addr]; -> REPLY0.
- Replies: write OK = 0x06; read OK = 0x06 then data byte; error = 0x15 only. Errored frames never write.
- REPLY0 sends first byte; REPLY1 sends data byte (read OK only); then IDLE.
- Any rx_i_v during EXEC/REPLY0/REPLY1: byte dropped, err_o pulses.
- Timeout: in CMD/ADDR/DATA/CHK, counter clears on each byte; reaching TIMEOUT -> IDLE, err_o pulse, no reply.
- err_o also pulses in EXEC for NAK frames.
- Register reset value 0x00; led_o = regs[0] registered.

## Timing
- Reset: state IDLE, regs 0, led_o=0x00, tx_o=0x00, tx_o_v=0, err_o=0, timeout counter 0. Reset mid-frame or mid-reply abandons it; no partial byte strobed.
- Each rx_i_v advances state on that edge; last frame byte -> EXEC next cycle.
- Write: led_o (addr 0) shows new value the cycle after EXEC.
- Tx handshake: strobe tx_o_v only when tx_busy_i=0 and no strobe in the previous 2 cycles (covers transmitter busy-flag latency). Earliest first reply strobe is the cycle after EXEC.
- tx_o holds its value until the next strobe.
- rx_i_v coinciding with timeout expiry: timeout wins, byte dropped.

## Configuration
- UART_CMD_CHKSUM_EN defined: CHK byte required = XOR of CMD, ADDR and DATA (write) or CMD, ADDR (read). Mismatch gives NAK 0x15, no write, err_o pulse.
- Undefined: no CHK state. Frame ends at DATA (write) or ADDR (read).

## Test plan
- Write: A5 57 00 3C [+chk 6B] -> led_o=0x3C one cycle after EXEC, single reply 0x06, err_o never high.
- Read: A5 57 05 81 [+chk D3], then A5 52 05 [+chk 57] -> replies 06, then 06 81, with at least 3 cycles between strobes.
- Bad frames: A5 41 -> reply 15, err_o pulse. A5 52 09 (ADDR_WIDTH=3) -> 15. With checksum built, bad CHK -> 15 and register unchanged.
- Timeout: A5 57 then silence for TIMEOUT cycles -> err_o pulse, no tx_o_v. Following A5 52 00 succeeds.
- Backpressure/overrun: hold tx_busy_i=1 for 200 cycles after a read frame -> no strobe until release. Byte received meanwhile -> err_o pulse, dropped.
- Reset mid-frame: rst_i=0 for one cycle after A5 57 01 -> all outputs reset. Subsequent 42 byte ignored silently.
